// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM stream reader and other dp_ram read-side users.
package ram_stream_pkg;

    typedef enum logic [1:0] {
        FLUSH,
        IDLE,
        READ,
        DRAIN
    } rsr_state_t;

    localparam int RAM_RD_LATENCY = 2;

endpackage

// File: rtl/rsr_sync_fifo.sv
// Single-clock FIFO with a registered output stage; the output register is loaded
// from storage or, when storage is empty, directly from the write port.
module rsr_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;

    logic mem_empty;
    logic load;
    logic take_mem;
    logic bypass;
    logic mem_wr;

    always_comb begin
        mem_empty = (count_reg == '0);
        load      = !out_valid_reg || rd_ready;
        take_mem  = load && !mem_empty;
        bypass    = load && mem_empty && wr_en;
        mem_wr    = wr_en && !bypass && !clear;
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (mem_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (take_mem) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (mem_wr && !take_mem) begin
                count_reg <= count_reg + 1'b1;
            end else if (!mem_wr && take_mem) begin
                count_reg <= count_reg - 1'b1;
            end
            // Output word only changes when consumed or empty, so it holds under backpressure.
            if (load) begin
                out_valid_reg <= take_mem || bypass;
                if (take_mem) begin
                    out_data_reg <= mem[rd_ptr_reg];
                end else if (bypass) begin
                    out_data_reg <= wr_data;
                end
            end
        end
    end

    assign rd_valid = out_valid_reg;
    assign rd_data  = out_data_reg;

endmodule

// File: rtl/ram_stream_reader.sv
// Burst read controller for dp_ram: issues reads under a credit limit and streams words out.
// Optional burst abort input is enabled by defining RAM_STREAM_READER_ABORT_EN.
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 8
) (
    input  logic                  oclk,
    input  logic                  orst,
`ifdef RAM_STREAM_READER_ABORT_EN
    input  logic                  abort,
`endif
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_rd,
    input  logic [DATA_WIDTH-1:0] ram_data,
    input  logic                  ram_data_valid,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int              OW         = $clog2(BUF_DEPTH) + 1;
    localparam logic [OW-1:0]   BUF_FULL   = OW'(BUF_DEPTH);
    localparam int              FW         = $clog2(RAM_RD_LATENCY) + 1;
    localparam logic [FW-1:0]   FLUSH_LAST = FW'(RAM_RD_LATENCY - 1);

    rsr_state_t            state_reg, state_next;
    logic [FW-1:0]         flush_cnt_reg, flush_cnt_next;
    logic [OW-1:0]         outstanding_reg, outstanding_next;
    logic [ADDR_WIDTH-1:0] remaining_reg, remaining_next;
    logic [ADDR_WIDTH-1:0] rx_left_reg, rx_left_next;
    logic [ADDR_WIDTH-1:0] ram_addr_reg, ram_addr_next;
    logic                  ram_rd_reg;
    logic                  cmd_ready_reg;

    logic                  issue;
    logic                  pop;
    logic                  abort_hit;
    logic                  buf_wr;
    logic                  buf_last;
    logic [DATA_WIDTH:0]   buf_out;

`ifdef RAM_STREAM_READER_ABORT_EN
    assign abort_hit = abort && ((state_reg == READ) || (state_reg == DRAIN));
`else
    assign abort_hit = 1'b0;
`endif

    assign pop = m_valid && m_ready;

    // The first read is issued in the accept cycle so ram_rd is visible one cycle later.
    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = '0;
        issue          = 1'b0;
        ram_addr_next  = ram_addr_reg;
        remaining_next = remaining_reg;
        case (state_reg)
            FLUSH: begin
                if (flush_cnt_reg == FLUSH_LAST) begin
                    state_next = IDLE;
                end else begin
                    flush_cnt_next = flush_cnt_reg + 1'b1;
                end
            end
            IDLE: begin
                if (cmd_valid) begin
                    issue          = 1'b1;
                    ram_addr_next  = cmd_addr;
                    remaining_next = cmd_len;
                    state_next     = (cmd_len == '0) ? DRAIN : READ;
                end
            end
            READ: begin
                if (outstanding_reg < BUF_FULL) begin
                    issue          = 1'b1;
                    ram_addr_next  = ram_addr_reg + 1'b1;
                    remaining_next = remaining_reg - 1'b1;
                    if (remaining_reg == ADDR_WIDTH'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = FLUSH;
        endcase
        if (abort_hit) begin
            state_next = FLUSH;
            issue      = 1'b0;
        end
    end

    // Last tag is assigned on the receive side by counting returned words.
    always_comb begin
        buf_wr       = ram_data_valid && (state_reg != FLUSH);
        buf_last     = (rx_left_reg == '0);
        rx_left_next = rx_left_reg;
        if ((state_reg == IDLE) && cmd_valid) begin
            rx_left_next = cmd_len;
        end else if (buf_wr) begin
            rx_left_next = rx_left_reg - 1'b1;
        end
        outstanding_next = outstanding_reg;
        if (abort_hit) begin
            outstanding_next = '0;
        end else if (issue && !pop) begin
            outstanding_next = outstanding_reg + 1'b1;
        end else if (!issue && pop) begin
            outstanding_next = outstanding_reg - 1'b1;
        end
    end

    always_ff @(posedge oclk) begin
        if (orst) begin
            state_reg       <= FLUSH;
            flush_cnt_reg   <= '0;
            outstanding_reg <= '0;
            remaining_reg   <= '0;
            rx_left_reg     <= '0;
            ram_addr_reg    <= '0;
            ram_rd_reg      <= 1'b0;
            cmd_ready_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            flush_cnt_reg   <= flush_cnt_next;
            outstanding_reg <= outstanding_next;
            remaining_reg   <= remaining_next;
            rx_left_reg     <= rx_left_next;
            ram_addr_reg    <= ram_addr_next;
            ram_rd_reg      <= issue;
            cmd_ready_reg   <= (state_next == IDLE);
        end
    end

    rsr_sync_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_buf (
        .clk      (oclk),
        .srst     (orst),
        .clear    (abort_hit),
        .wr_en    (buf_wr),
        .wr_data  ({buf_last, ram_data}),
        .rd_ready (m_ready),
        .rd_valid (m_valid),
        .rd_data  (buf_out)
    );

    assign m_data    = buf_out[DATA_WIDTH-1:0];
    assign m_last    = buf_out[DATA_WIDTH];
    assign ram_addr  = ram_addr_reg;
    assign ram_rd    = ram_rd_reg;
    assign cmd_ready = cmd_ready_reg;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader with a 2-cycle-latency RAM model.
module tb_ram_stream_reader;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          oclk = 1'b0;
    logic          orst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW-1:0] cmd_len = '0;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic [DW-1:0] ram_data = '0;
    logic          ram_data_valid = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_last;
`ifdef RAM_STREAM_READER_ABORT_EN
    logic          abort = 1'b0;
`endif

    ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUF_DEPTH(8)) dut (
        .oclk           (oclk),
        .orst           (orst),
`ifdef RAM_STREAM_READER_ABORT_EN
        .abort          (abort),
`endif
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .ram_addr       (ram_addr),
        .ram_rd         (ram_rd),
        .ram_data       (ram_data),
        .ram_data_valid (ram_data_valid),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last)
    );

    always #5 oclk = ~oclk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic [DW-1:0] ram_mem [1024];
    exp_t          exp_q[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            acc_cyc = 0;
    int            done_cyc = 0;
    int            rd_count = 0;
    int            rd_base = 0;
    int            beat_cnt = 0;
    int            first_beat_cyc = 0;
    int            last_beat_cyc = 0;
    bit            rand_ready = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    // RAM model: read sampled on the clock edge, data returned two cycles later.
    logic          p1_v = 1'b0;
    logic [AW-1:0] p1_a = '0;
    always @(posedge oclk) begin
        p1_v           <= ram_rd;
        p1_a           <= ram_addr;
        ram_data_valid <= p1_v;
        ram_data       <= ram_mem[p1_a];
    end

    always @(posedge oclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat.
    always @(negedge oclk) begin
        exp_t e;
        if (!orst) begin
            if (prev_stall && m_valid) begin
                check("hold_data", 64'(m_data), 64'(prev_data));
                check("hold_last", 64'(m_last), 64'(prev_last));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual data=%0h last=%0b required=no beat (cycle %0d)",
                             m_data, m_last, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(m_data), 64'(e.data));
                    check("beat_last", 64'(m_last), 64'(e.last));
                    beat_cnt++;
                    if (beat_cnt == 1) first_beat_cyc = cyc;
                    last_beat_cyc = cyc;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            prev_stall = 1'b0;
        end
        if (ram_rd) rd_count++;
    end

    initial begin
        forever begin
            @(posedge oclk);
            #1;
            if (rand_ready) m_ready = ($urandom_range(3) != 0);
        end
    end

    task automatic tick();
        @(posedge oclk);
        #1;
    endtask

    task automatic send_cmd(input int addr, input int len);
        int n = 0;
        exp_t e;
        logic [AW-1:0] a;
        cmd_addr  = AW'(addr);
        cmd_len   = AW'(len);
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL cmd_accept actual=cmd_ready low for %0d cycles required=accept", n);
            cmd_valid = 1'b0;
            return;
        end
        acc_cyc  = cyc;
        rd_base  = rd_count;
        beat_cnt = 0;
        for (int i = 0; i <= len; i++) begin
            a      = AW'(addr + i);
            e.data = ram_mem[a];
            e.last = (i == len);
            exp_q.push_back(e);
        end
        tick();
        cmd_valid = 1'b0;
        $display("cmd addr=%0d len=%0d accepted at cycle %0d", addr, len, acc_cyc);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && cmd_ready) && n < budget) begin
            tick();
            n++;
        end
        done_cyc = cyc;
        check("burst_done_in_time", 64'(n < budget), 64'(1));
        $display("burst done: beats=%0d first=%0d last=%0d ready_again=%0d",
                 beat_cnt, first_beat_cyc - acc_cyc, last_beat_cyc - acc_cyc, done_cyc - acc_cyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, 64'(m_valid), 64'(0));
        check({tag, "_m_last"}, 64'(m_last), 64'(0));
        check({tag, "_m_data"}, 64'(m_data), 64'(0));
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(0));
        check({tag, "_ram_rd"}, 64'(ram_rd), 64'(0));
        check({tag, "_ram_addr"}, 64'(ram_addr), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram_mem[i] = $urandom;

        // Power-on reset and FLUSH length
        orst = 1'b1;
        tick();
        tick();
        @(negedge oclk);
        check_reset_outputs("rst");
        tick();
        orst = 1'b0;
        check("ready_rel0", 64'(cmd_ready), 64'(0));
        tick();
        check("ready_rel1", 64'(cmd_ready), 64'(0));
        tick();
        check("ready_rel2", 64'(cmd_ready), 64'(1));

        // Single word
        m_ready = 1'b1;
        send_cmd(5, 0);
        wait_done(100);
        check("single_first_lat", 64'(first_beat_cyc - acc_cyc), 64'(4));
        check("single_beats", 64'(beat_cnt), 64'(1));
        check("single_ready_again", 64'(done_cyc - acc_cyc), 64'(5));

        // 16-word back-to-back burst
        send_cmd(0, 15);
        wait_done(200);
        check("b16_first_lat", 64'(first_beat_cyc - acc_cyc), 64'(4));
        check("b16_last_cyc", 64'(last_beat_cyc - acc_cyc), 64'(19));
        check("b16_beats", 64'(beat_cnt), 64'(16));

        // Backpressure: 32 words, sink stalled through cycle 20
        m_ready = 1'b0;
        send_cmd(100, 31);
        while (cyc < acc_cyc + 20) tick();
        @(negedge oclk);
        check("bp_reads_stalled", 64'(rd_count - rd_base), 64'(8));
        check("bp_valid_held", 64'(m_valid), 64'(1));
        tick();
        m_ready = 1'b1;
        wait_done(500);
        check("bp_beats", 64'(beat_cnt), 64'(32));
        check("bp_total_reads", 64'(rd_count - rd_base), 64'(32));

        // Address wrap-around
        send_cmd(1022, 3);
        wait_done(100);
        check("wrap_beats", 64'(beat_cnt), 64'(4));

        // Reset in the middle of a burst
        send_cmd(0, 15);
        while (cyc < acc_cyc + 6) tick();
        orst = 1'b1;
        exp_q.delete();
        tick();
        orst = 1'b0;
        @(negedge oclk);
        check_reset_outputs("midrst");
        tick();
        check("midrst_ready_r1", 64'(cmd_ready), 64'(0));
        tick();
        check("midrst_ready_r2", 64'(cmd_ready), 64'(1));
        send_cmd(300, 9);
        wait_done(200);
        check("post_rst_beats", 64'(beat_cnt), 64'(10));

`ifdef RAM_STREAM_READER_ABORT_EN
        // Abort in the middle of a burst
        send_cmd(50, 15);
        while (cyc < acc_cyc + 7) tick();
        abort = 1'b1;
        @(negedge oclk);
        #1;
        exp_q.delete();
        tick();
        abort = 1'b0;
        @(negedge oclk);
        check("abort_valid_c8", 64'(m_valid), 64'(0));
        tick();
        @(negedge oclk);
        check("abort_valid_c9", 64'(m_valid), 64'(0));
        tick();
        check("abort_ready_c10", 64'(cmd_ready), 64'(1));
        send_cmd(700, 12);
        wait_done(200);
        check("post_abort_beats", 64'(beat_cnt), 64'(13));
`endif

        // Random bursts with random sink backpressure
        rand_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            int len;
            len = int'($urandom_range(40));
            send_cmd(int'($urandom_range(1023)), len);
            wait_done(2000);
            check("rand_beats", 64'(beat_cnt), 64'(len + 1));
        end
        rand_ready = 1'b0;
        m_ready = 1'b1;
        repeat (5) tick();
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
